// File: rtl/fifo_rd_adapter.sv
// Read-side adapter for async_fifo_8x32: issues rd_en, absorbs the one-cycle read latency and
// presents flits on a valid/ready stream through a 3-entry prefetch buffer.
module fifo_rd_adapter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  flit_cnt
);

    logic [DATA_WIDTH-1:0] buf_mem_q [3];
    logic [DATA_WIDTH-1:0] buf_mem_d [3];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  flit_cnt_q, flit_cnt_d;
    logic [2:0]            occ;
    logic                  rd_req;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        // Words already held plus the one returning; a new read needs a guaranteed free slot.
        occ        = 3'(cnt_q) + 3'(inflight_q);
        rd_req     = !fifo_empty && (occ <= 3'd2);
        fifo_rd_en = rd_req && rst;
        out_valid  = (cnt_q != 2'd0);
        out_data   = buf_mem_q[rd_ptr_q];
        pop        = out_valid && out_ready;
        flit_cnt   = flit_cnt_q;

        buf_mem_d  = buf_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        flit_cnt_d = flit_cnt_q;
        inflight_d = rd_req;

        if (inflight_q) begin
            buf_mem_d[wr_ptr_q] = fifo_rd_data;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            flit_cnt_d = flit_cnt_q + CNT_WIDTH'(1);
        end
        cnt_d = cnt_q + 2'(inflight_q) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem_q[i] <= '0;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            flit_cnt_q <= '0;
        end else begin
            buf_mem_q  <= buf_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    capture_into_full: assert property (
        @(posedge clk) disable iff (!rst) !(inflight_q && (cnt_q == 2'd3))
    ) else $error("capture into full prefetch buffer");

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: behavioural read-domain FIFO model, in-order scoreboard and
// directed steps for reset, latency, streaming, back-pressure, random ready and mid-run reset.
module tb_fifo_rd_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = 32'h0;
    logic        fifo_empty = 1'b1;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [15:0] flit_cnt;

    logic [31:0] src_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          wr_per_cycle = 2;
    bit          fifo_clear = 1'b0;

    int tests = 0;
    int fails = 0;
    int fetched = 0;
    int delivered = 0;
    int exp_flit = 0;
    int max_out = 0;

    fifo_rd_adapter #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flit_cnt    (flit_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Depth-8 FIFO read port with one-cycle read latency; writer moves up to wr_per_cycle words in.
    always @(posedge clk) begin
        if (fifo_clear) begin
            fifo_q.delete();
        end else if (fifo_rd_en) begin
            check("fifo_read_not_empty", 32'(fifo_q.size() != 0), 32'd1);
            if (fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
        end
        for (int i = 0; i < wr_per_cycle; i++) begin
            if (src_q.size() != 0 && fifo_q.size() < 8) fifo_q.push_back(src_q.pop_front());
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            fetched   = 0;
            delivered = 0;
            exp_flit  = 0;
        end else begin
            if (fifo_rd_en) fetched++;
            if (fetched - delivered > max_out) max_out = fetched - delivered;
            if (out_valid && out_ready) begin
                check("flit_cnt_at_pop", 32'(flit_cnt), 32'(16'(exp_flit)));
                check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("out_data_order", out_data, exp_q.pop_front());
                exp_flit++;
                delivered++;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic wait_idle(input int budget);
        int  k;
        bit  idle;
        k = 0;
        idle = 1'b0;
        while (!idle && k < budget) begin
            @(negedge clk);
            idle = (src_q.size() == 0) && (exp_q.size() == 0) && fifo_empty
                   && !out_valid && !fifo_rd_en;
            k++;
        end
        check("idle_reached", 32'(idle), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        int pulses;

        // Reset with the FIFO preloaded.
        rst       = 1'b0;
        out_ready = 1'b1;
        push_word(32'h11);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flit_cnt", 32'(flit_cnt), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("first_rd_en_after_release", 32'(fifo_rd_en), 32'd1);
        wait_idle(50);

        // Single flit: out_valid two edges after the strobe.
        push_word(32'h1);
        k = 0;
        while (!fifo_rd_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("single_rd_en_seen", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        check("single_valid_after_1_edge", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_valid_after_2_edges", 32'(out_valid), 32'd1);
        check("single_data", out_data, 32'h1);
        wait_idle(50);
        check("single_flit_cnt", 32'(flit_cnt), 32'd2);

        // Streaming 64 flits at twice the read rate.
        for (int i = 1; i <= 64; i++) push_word(32'(i));
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        n = 0;
        while (out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stream_gapless_len", 32'(n), 32'd64);
        wait_idle(100);
        check("stream_flit_cnt", 32'(flit_cnt), 32'd66);

        // Back-pressure: 8 words, ready low for 20 cycles.
        set_ready(1'b0);
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd_en) pulses++;
        end
        check("bp_rd_pulses", 32'(pulses), 32'd3);
        check("bp_held_valid", 32'(out_valid), 32'd1);
        check("bp_held_data", out_data, 32'h1);
        set_ready(1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bp_drain_consecutive", 32'(out_valid), 32'd1);
        end
        wait_idle(50);
        check("bp_flit_cnt", 32'(flit_cnt), 32'd74);

        // Random ready over 1000 flits.
        wr_per_cycle = 1;
        for (int i = 0; i < 1000; i++) push_word(32'h1000 + 32'(i));
        k = 0;
        while (exp_q.size() != 0 && k < 10000) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        check("rand_all_delivered", 32'(exp_q.size()), 32'd0);
        set_ready(1'b1);
        wait_idle(50);
        check("rand_flit_cnt", 32'(flit_cnt), 32'd1074);
        check("outstanding_peak", 32'(max_out), 32'd3);

        // Reset while a read is in flight and two words are buffered.
        wr_per_cycle = 2;
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i));
        pulses = 0;
        k = 0;
        while (pulses < 3 && k < 40) begin
            @(negedge clk);
            if (fifo_rd_en) pulses++;
            k++;
        end
        check("pre_rst_pulses", 32'(pulses), 32'd3);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        fifo_clear = 1'b1;
        #1;
        check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_flit_cnt", 32'(flit_cnt), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        fifo_clear = 1'b0;
        push_word(32'hA5);
        out_ready = 1'b1;
        rst = 1'b1;
        wait_idle(50);
        check("midrst_restart_flit_cnt", 32'(flit_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
